// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-subset control FSM (fetch/decode/execute/memory/writeback).
// Ports:
//   Clock, Reset          - clock and synchronous active-high reset
//   Op, Funct             - opcode / function fields of the held instruction register
//   Zero, MemReady        - ALU zero flag, memory handshake (access completes when 1)
//   PCEn, PCSrc, IorD     - PC load enable / source select, memory address select
//   MemRead, MemWrite     - memory strobes
//   IRWrite, RegWrite     - instruction register / register file write enables
//   RegDst, MemtoReg      - destination register / writeback source selects
//   ALUSrcA, ALUSrcB      - ALU operand selects
//   ALUCtrl               - ALU operation
//   State                 - current FSM state (debug)
//   Done, Illegal         - retire pulse, unsupported-instruction pulse
module multicycle_ctrl (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtrl,
  output logic [3:0] State,
  output logic       Done,
  output logic       Illegal
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    ILLEGAL = 4'd12
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  state_t state, nxt;
  logic   r_legal;
  assign State = state;
  assign r_legal = Funct == 6'b100000 || Funct == 6'b100010 || Funct == 6'b100100 ||
                   Funct == 6'b100101 || Funct == 6'b101010;
  always_ff @(posedge Clock)
    state <= Reset ? FETCH : nxt;
  // While in reset the outputs decode as FETCH, then every write/pulse is masked,
  // so an interrupted instruction can never leave a partial update behind.
  always_comb begin
    nxt      = FETCH;
    PCEn     = 1'b0;
    PCSrc    = 2'b00;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUCtrl  = 3'b000;
    Done     = 1'b0;
    Illegal  = 1'b0;
    case (Reset ? FETCH : state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUCtrl = 3'b010;
        IRWrite = MemReady;
        PCEn    = MemReady;
        nxt     = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ALUCtrl = 3'b010;
        nxt     = (Op == OP_R && r_legal)        ? EXEC   :
                  (Op == OP_LW || Op == OP_SW)   ? MEMADR :
                  Op == OP_BEQ                   ? BRANCH :
                  Op == OP_J                     ? JUMP   :
                  Op == OP_ADDI                  ? ADDIEX : ILLEGAL;
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUCtrl = 3'b010;
        nxt     = state == ADDIEX ? ADDIWB : Op == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        nxt     = MemReady ? MEMWB : MEMRD;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Done     = MemReady;
        nxt      = MemReady ? FETCH : MEMWR;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        Done     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUCtrl = Funct == 6'b100010 ? 3'b110 :
                  Funct == 6'b100100 ? 3'b000 :
                  Funct == 6'b100101 ? 3'b001 :
                  Funct == 6'b101010 ? 3'b111 : 3'b010;
        nxt     = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        Done     = 1'b1;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        Done     = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUCtrl = 3'b110;
        PCSrc   = 2'b01;
        PCEn    = Zero;
        Done    = 1'b1;
      end
      JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
        Done  = 1'b1;
      end
      ILLEGAL: Illegal = 1'b1;
      default: nxt = FETCH;
    endcase
    if (Reset) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Done     = 1'b0;
      Illegal  = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven scoreboard bench for multicycle_ctrl plus directed latency/pulse sequences.
module tb_multicycle_ctrl;
  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] Op = '0, Funct = '0;
  logic       Zero = 1'b0, MemReady = 1'b1;
  logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, Done, Illegal;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUCtrl;
  logic [3:0] State;
  logic [17:0] ctl;
  int checks = 0, failures = 0;

  multicycle_ctrl dut (
    .Clock(Clock), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCEn(PCEn), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .State(State),
    .Done(Done), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  assign ctl = {PCEn, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
                ALUSrcA, ALUSrcB, ALUCtrl, Done, Illegal};

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_NOP = 6'b000000;

  typedef struct {
    logic       rst;
    logic [5:0] op, fn;
    logic       z, mr;
    logic [3:0] st;
  } vec_t;
  typedef struct {
    int          row;
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];

  // Expected control word for a state, built directly from the state descriptions.
  function automatic logic [17:0] exp_ctl(logic [3:0] st, logic [5:0] fn, logic z, logic mr, logic rst);
    logic pcen, iord, mrd, mwr, irw, rw, rd, m2r, asa, dn, il;
    logic [1:0] pcs, asb;
    logic [2:0] alu;
    logic [3:0] s;
    {pcen, iord, mrd, mwr, irw, rw, rd, m2r, asa, dn, il} = '0;
    pcs = 2'b00; asb = 2'b00; alu = 3'b000;
    s = rst ? 4'd0 : st;
    case (s)
      4'd0: begin mrd = 1; asb = 2'b01; alu = 3'b010; irw = mr & ~rst; pcen = mr & ~rst; end
      4'd1: begin asb = 2'b11; alu = 3'b010; end
      4'd2, 4'd10: begin asa = 1; asb = 2'b10; alu = 3'b010; end
      4'd3: begin mrd = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; dn = 1; end
      4'd5: begin mwr = 1; iord = 1; dn = mr; end
      4'd6: begin
        asa = 1;
        case (fn)
          F_ADD: alu = 3'b010;
          F_SUB: alu = 3'b110;
          F_AND: alu = 3'b000;
          F_OR:  alu = 3'b001;
          F_SLT: alu = 3'b111;
          default: alu = 3'b010;
        endcase
      end
      4'd7: begin rw = 1; rd = 1; dn = 1; end
      4'd8: begin asa = 1; alu = 3'b110; pcs = 2'b01; pcen = z; dn = 1; end
      4'd9: begin pcs = 2'b10; pcen = 1; dn = 1; end
      4'd11: begin rw = 1; dn = 1; end
      4'd12: il = 1;
      default: ;
    endcase
    return {pcen, pcs, iord, mrd, mwr, irw, rw, rd, m2r, asa, asb, alu, dn, il};
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [3:0] st);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] s3, input int n);
    add(0, op, fn, z, 1, s0);
    add(0, op, fn, z, 1, s1);
    add(0, op, fn, z, 1, s2);
    if (n > 3) add(0, op, fn, z, 1, s3);
  endtask

  task automatic latency(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int want);
    int n;
    Op = op; Funct = fn; Zero = z; MemReady = 1; Reset = 0;
    n = 0;
    forever begin
      @(negedge Clock);
      n++;
      if (Done || n > 20) break;
      @(posedge Clock); #1;
    end
    check({name, "_latency"}, n, want);
    @(posedge Clock); #1;
    check({name, "_back_to_fetch"}, State, 0);
  endtask

  initial begin
    int il_cnt, wr_cnt;
    logic [3:0] seq[4];
    repeat (2) @(posedge Clock);
    #1;
    add(1, R, F_ADD, 0, 1, 0);
    instr(R, F_ADD, 0, 0, 1, 6, 7, 4);
    instr(R, F_SUB, 0, 0, 1, 6, 7, 4);
    instr(R, F_AND, 0, 0, 1, 6, 7, 4);
    instr(R, F_OR,  0, 0, 1, 6, 7, 4);
    instr(R, F_SLT, 0, 0, 1, 6, 7, 4);
    add(0, LW, F_NOP, 0, 1, 0); add(0, LW, F_NOP, 0, 1, 1); add(0, LW, F_NOP, 0, 1, 2);
    add(0, LW, F_NOP, 0, 0, 3); add(0, LW, F_NOP, 0, 0, 3); add(0, LW, F_NOP, 0, 1, 3);
    add(0, LW, F_NOP, 0, 1, 4);
    instr(SW, F_NOP, 0, 0, 1, 2, 5, 4);
    instr(BEQ, F_NOP, 1, 0, 1, 8, 0, 3);
    instr(BEQ, F_NOP, 0, 0, 1, 8, 0, 3);
    instr(JMP, F_NOP, 0, 0, 1, 9, 0, 3);
    instr(ADDI, F_NOP, 0, 0, 1, 10, 11, 4);
    instr(BAD, F_NOP, 0, 0, 1, 12, 0, 3);
    instr(R, F_NOP, 0, 0, 1, 12, 0, 3);
    add(0, JMP, F_NOP, 0, 0, 0); add(0, JMP, F_NOP, 0, 0, 0); add(0, JMP, F_NOP, 0, 0, 0);
    add(0, JMP, F_NOP, 0, 1, 0); add(0, JMP, F_NOP, 0, 1, 1); add(0, JMP, F_NOP, 0, 1, 9);
    add(0, SW, F_NOP, 0, 1, 0); add(0, SW, F_NOP, 0, 1, 1); add(0, SW, F_NOP, 0, 1, 2);
    add(0, SW, F_NOP, 0, 0, 5); add(0, SW, F_NOP, 0, 1, 5);
    add(0, SW, F_NOP, 0, 1, 0); add(0, SW, F_NOP, 0, 1, 1); add(0, SW, F_NOP, 0, 1, 2);
    add(1, SW, F_NOP, 0, 1, 5);
    instr(JMP, F_NOP, 0, 0, 1, 9, 0, 3);
    add(0, LW, F_NOP, 0, 1, 0); add(0, LW, F_NOP, 0, 1, 1); add(0, LW, F_NOP, 0, 1, 2);
    add(1, LW, F_NOP, 0, 0, 3);
    add(0, LW, F_NOP, 0, 0, 0);
    foreach (tbl[i]) begin
      exp_t e;
      Reset = tbl[i].rst; Op = tbl[i].op; Funct = tbl[i].fn; Zero = tbl[i].z; MemReady = tbl[i].mr;
      e.row = i; e.st = tbl[i].st;
      e.ctl = exp_ctl(tbl[i].st, tbl[i].fn, tbl[i].z, tbl[i].mr, tbl[i].rst);
      sb.push_back(e);
      @(negedge Clock);
      e = sb.pop_front();
      checks++;
      if (State !== e.st) begin
        failures++;
        $display("FAIL row%0d_state got=%0d want=%0d", e.row, State, e.st);
      end
      checks++;
      if (ctl !== e.ctl) begin
        failures++;
        $display("FAIL row%0d_ctl got=%b want=%b", e.row, ctl, e.ctl);
      end
      checks++;
      if (MemRead && MemWrite) begin
        failures++;
        $display("FAIL row%0d_mem_excl got=11 want=not both", e.row);
      end
      @(posedge Clock); #1;
    end
    Reset = 1;
    @(posedge Clock); #1;
    latency("add", R, F_ADD, 0, 4);
    latency("addi", ADDI, F_NOP, 0, 4);
    latency("lw", LW, F_NOP, 0, 5);
    latency("sw", SW, F_NOP, 0, 4);
    latency("beq_t", BEQ, F_NOP, 1, 3);
    latency("beq_nt", BEQ, F_NOP, 0, 3);
    latency("j", JMP, F_NOP, 0, 3);
    Op = BAD; Funct = F_NOP; MemReady = 1; Reset = 0;
    il_cnt = 0; wr_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      seq[k] = State;
      il_cnt += int'(Illegal);
      wr_cnt += int'(RegWrite) + int'(MemWrite);
      @(posedge Clock); #1;
    end
    check("illegal_seq", {seq[0], seq[1], seq[2], seq[3]}, 16'h01C0);
    check("illegal_pulses", il_cnt, 1);
    check("illegal_writes", wr_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
